// File: rtl/pooling_readout_controller.sv
// pooling_readout_controller: streams one frame of pooled words from the pooling buffer to the next layer.
// Up to two words are held (buffered or in flight), so read latency never causes overflow or bubbles.
module pooling_readout_controller #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_readout,
    input  logic [DATA_W-1:0] rd_data_pooling,
    input  logic              ready_out,
    output logic              re_pooling,
    output logic [31:0]       read_addr_readout,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              busy,
    output logic              done_readout,
    output logic              overrun
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [31:0] LAST = 32'(DEPTH - 1);

    logic [1:0]        state;
    logic [31:0]       addr, last_addr, out_cnt;
    logic              in_flight, wr_ptr, rd_ptr, pop, credit, issue;
    logic [1:0]        count;
    logic [DATA_W-1:0] mem [2];

    assign pop    = valid_out && ready_out;
    // buffered + in-flight words may never exceed the two FIFO slots
    assign credit = (count + 2'(in_flight)) < 2'd2 || pop;
    // the first read is issued in the start cycle so data leads by two cycles
    assign issue  = rst_n && ((state == IDLE && start_readout) || (state == ISSUE && credit));

    assign re_pooling        = issue;
    assign read_addr_readout = issue ? addr : last_addr;
    assign valid_out         = count != 2'd0;
    assign data_out          = mem[rd_ptr];
    assign last_out          = valid_out && out_cnt == LAST;
    assign busy              = state != IDLE;
    assign done_readout      = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            out_cnt   <= '0;
            in_flight <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            overrun   <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                last_addr <= addr;
                addr      <= addr == LAST ? '0 : addr + 32'd1;
            end
            if (in_flight) begin
                mem[wr_ptr] <= rd_data_pooling;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= last_out ? '0 : out_cnt + 32'd1;
            end
            count <= count + 2'(in_flight) - 2'(pop);
            if (start_readout) overrun <= busy;
            state <= (issue && addr == LAST) ? DRAIN :
                     (state == IDLE && start_readout) ? ISSUE :
                     (state == DRAIN && pop && last_out) ? DONE :
                     (state == DONE) ? IDLE : state;
        end
    end
endmodule

// File: doc/pooling_readout_controller.md
POOLING_READOUT_CONTROLLER -- requirements
Module: pooling_readout_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one pooled result word.
REQ-002 SHALL have parameter DEPTH, default 192, number of pooled words per frame.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_readout, input, 1, one-cycle pulse: pooling buffer holds a complete frame.
REQ-006 SHALL have port rd_data_pooling, input, DATA_W, pooling buffer read data, valid exactly 1 cycle after re_pooling.
REQ-007 SHALL have port ready_out, input, 1, downstream layer accepts data_out this cycle.
REQ-008 SHALL have port re_pooling, output, 1, pooling buffer read enable.
REQ-009 SHALL have port read_addr_readout, output, 32, pooling buffer read address.
REQ-010 SHALL have port data_out, output, DATA_W, pooled word to next layer.
REQ-011 SHALL have port valid_out, output, 1, data_out is valid.
REQ-012 SHALL have port last_out, output, 1, asserted with valid_out on word index DEPTH-1.
REQ-013 SHALL have port busy, output, 1, frame readout in progress.
REQ-014 SHALL have port done_readout, output, 1, one-cycle pulse after final word handshake.
REQ-015 SHALL have port overrun, output, 1, sticky: start_readout arrived while busy.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE: on start_readout SHALL go to ISSUE, set busy=1, clear address counter and overrun.
REQ-018 ISSUE: SHALL assert re_pooling with read_addr_readout = current address when credit exists; address increments by 1 per issued read.
REQ-019 Credit SHALL mean (output-buffer entries + reads in flight) < 2, OR valid_out&&ready_out in the same cycle.
REQ-020 SHALL hold an internal 2-entry FIFO; rd_data_pooling SHALL be written into it the cycle after each issued read.
REQ-021 valid_out SHALL equal FIFO non-empty; data_out SHALL be FIFO head; a word is consumed only on valid_out&&ready_out.
REQ-022 While valid_out=1 and ready_out=0, data_out and last_out SHALL remain stable.
REQ-023 With ready_out held 1, SHALL sustain one word per cycle; first valid_out 2 cycles after start_readout.
REQ-024 After issuing address DEPTH-1, SHALL go to DRAIN, deassert re_pooling, issue no further reads.
REQ-025 DRAIN: when the word with last_out=1 is handshaken SHALL go to DONE.
REQ-026 DONE: SHALL pulse done_readout for exactly 1 cycle, set busy=0, return to IDLE; address counter SHALL read 0.
REQ-027 start_readout while busy=1 (including the DONE cycle) SHALL be ignored and SHALL set overrun=1.
REQ-028 Output word count per frame SHALL be exactly DEPTH, in ascending address order, no duplicates or drops.
REQ-029 read_addr_readout SHALL hold its last value when re_pooling=0.
REQ-030 start_readout in IDLE SHALL be accepted in the same cycle ready_out/other inputs change; inputs in IDLE besides start_readout SHALL be ignored.

Reset
REQ-031 On rst_n=0, regardless of state: re_pooling=0, read_addr_readout=0, valid_out=0, last_out=0, data_out=0, busy=0, done_readout=0, overrun=0, FIFO empty, FSM=IDLE.
REQ-032 Reset mid-frame SHALL discard in-flight and buffered words; no valid_out until next start_readout after reset release.

Verification
REQ-033 DEPTH=4, ready_out=1, buffer data = addr+100, start pulse at cycle 0 -> valid_out cycles 2..5 with data 100,101,102,103, last_out on 103, done_readout at cycle 6.
REQ-034 DEPTH=4, ready_out=0 for cycles 0-9 then 1 -> exactly 2 reads issued before stall, data_out=100 stable cycles 2-9, then all 4 words in order, no loss.
REQ-035 ready_out toggling 1,0,1,0 -> each word presented until accepted; 4 handshakes total; re_pooling never issues with 2 entries+inflight and no pop.
REQ-036 start_readout again at cycle 3 of frame -> overrun=1, frame completes unchanged with 4 words; next accepted start clears overrun.
REQ-037 rst_n low at cycle 3 with 2 words buffered -> all outputs to reset values asynchronously; after release, no valid_out until new start_readout; new frame starts at address 0.
REQ-038 Default DEPTH=192 back-to-back frames (start at cycle after done_readout) -> 384 words, addresses 0..191 twice, two done_readout pulses, overrun=0.
